cavg_power_detect: RTL and testbench
====================================

Name: cavg_power_detect

Overview:
- Downstream consumer of the complex moving-average stage.
- Takes the averaged I/Q AXI-Stream, computes instantaneous power I²+Q², and passes the power through on its own stream.
- Runs a qualified threshold detector with hysteresis and marks each output beat with detect state and a start-of-detection flag.
- Feeds burst/preamble gating logic downstream.

Parameters:
- DATA_WIDTH, 16: width of signed two's-complement I and Q inputs.
- RUN_WIDTH, 8: width of the qualification run counters and min_run input.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear: flushes pipeline and returns FSM to IDLE.
- thresh_on  input  2*DATA_WIDTH  unsigned power level to enter detection.
- thresh_off  input  2*DATA_WIDTH  unsigned power level to leave detection. Software guarantees thresh_off <= thresh_on.
- min_run  input  RUN_WIDTH  consecutive qualifying samples required for either transition. Value 0 is treated as 1.
- in_tvalid  input  1  input beat valid.
- in_tlast  input  1  input end-of-packet.
- in_tready  output  1  input ready.
- in_itdata  input  DATA_WIDTH  averaged I, signed.
- in_qtdata  input  DATA_WIDTH  averaged Q, signed.
- out_tvalid  output  1  output beat valid.
- out_tlast  output  1  tlast delayed with its beat.
- out_tready  input  1  downstream ready.
- out_pwr  output  2*DATA_WIDTH  unsigned I²+Q².
- out_det  output  1  detector state is ACTIVE or RELEASE for this beat.
- out_start  output  1  this beat is the first beat with out_det=1 after IDLE/QUALIFY.

Behaviour:
- Reset (async) and clear (sync) values: out_tvalid=0, out_tlast=0, out_pwr=0, out_det=0, out_start=0. FSM goes to IDLE and run counter to 0. in_tready=1 after reset deasserts.
- Clear has priority over a same-cycle handshake; that input beat is dropped.
- Pipeline is 2 stages:
  - S1 registers I² and Q² (each 2*DATA_WIDTH-1 bits, unsigned, max 2^(2*DATA_WIDTH-2)).
  - S2 registers the sum (2*DATA_WIDTH bits, never overflows) plus the det/start flags.
- Latency: an accepted beat appears on the output 2 cycles later when out_tready is held high.
- Pipeline enable: en = ~S2_valid | out_tready. in_tready = en. A stage advances only on en, so a bubble in S1 is not compressed while S2 is stalled.
- Full throughput: one beat per cycle when out_tready=1.
- Backpressure: out_* stays stable while out_tvalid=1 and out_tready=0. No beat is lost or duplicated.
- The FSM evaluates the S1→S2 sum once per beat advancing into S2. The flags it produces are registered alongside that beat. Let p = the sum and N = max(min_run,1).
  - IDLE: if p >= thresh_on, cnt=1 and go to QUALIFY (go straight to ACTIVE if N=1). Otherwise stay.
  - QUALIFY: if p >= thresh_on, cnt++; when cnt reaches N, go to ACTIVE. If p < thresh_on, cnt=0 and return to IDLE.
  - ACTIVE: if p < thresh_off, cnt=1 and go to RELEASE (go straight to IDLE if N=1). Otherwise stay.
  - RELEASE: if p < thresh_off, cnt++; when cnt reaches N, go to IDLE. If p >= thresh_off, cnt=0 and return to ACTIVE.
- out_det=1 on the beat causing the entry into ACTIVE and on all beats while in ACTIVE/RELEASE. It is 0 on the beat that completes the return to IDLE.
- out_start=1 only on the beat causing the QUALIFY→ACTIVE or IDLE→ACTIVE transition.
- Counter saturates at 2^RUN_WIDTH-1.
- Thresholds and min_run are sampled per beat; a mid-stream change takes effect on the next evaluated beat.
- tlast does not reset the FSM; detection state spans packets.
- Boundary values: the most negative input, -2^(DATA_WIDTH-1) on both I and Q, gives p = 2^(2*DATA_WIDTH-1), which is exact. p == thresh_on qualifies. p == thresh_off does not release.
- Reset asserted mid-stream drops all in-flight beats immediately.

Test Plan:
- Reset, then stream I=3,Q=4 for 5 beats with out_tready=1 → out_pwr=25 each beat, first output 2 cycles after the first accept, tlast preserved on beat 5.
- I=Q=-32768 → out_pwr=0x80000000. I=32767,Q=0 → out_pwr=0x3FFF0001.
- thresh_on=100, thresh_off=50, min_run=3; power sequence 120,120,40,120,120,120,60,40,40,40 → det 0,0,0,0,0,1,1,1,1,0 and start=1 only on beat 6.
- min_run=0, thresh_on=100 → first beat with p=100 gives det=1 and start=1.
- Random out_tready (~50%) over 1000 random beats vs a reference model → identical pwr/det/start/tlast sequence, no drops or duplicates, outputs stable while stalled.
- Assert clear during ACTIVE with 2 beats in flight → both beats dropped, out_tvalid=0 next cycle, next beat with p >= thresh_on restarts qualification from IDLE.

Source files
------------

// File: rtl/cavg_power_detect.sv
// Instantaneous power (I^2+Q^2) of the averaged I/Q stream, with a qualified
// hysteresis threshold detector whose flags ride along with each power beat.
module cavg_power_detect #(
  parameter int DATA_WIDTH = 16,
  parameter int RUN_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic [2*DATA_WIDTH-1:0]        thresh_on,
  input  logic [2*DATA_WIDTH-1:0]        thresh_off,
  input  logic [RUN_WIDTH-1:0]           min_run,
  input  logic                           in_tvalid,
  input  logic                           in_tlast,
  output logic                           in_tready,
  input  logic signed [DATA_WIDTH-1:0]   in_itdata,
  input  logic signed [DATA_WIDTH-1:0]   in_qtdata,
  output logic                           out_tvalid,
  output logic                           out_tlast,
  input  logic                           out_tready,
  output logic [2*DATA_WIDTH-1:0]        out_pwr,
  output logic                           out_det,
  output logic                           out_start
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW - 1;  // a square of a signed value never needs the top bit

  typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE, RELEASE} state_t;

  logic                 en;
  logic [SW-1:0]        i_sq, q_sq;
  logic                 s1_valid, s1_last;
  logic [SW-1:0]        s1_isq, s1_qsq;
  logic [PW-1:0]        sum;
  state_t               state, state_nxt;
  logic [RUN_WIDTH-1:0] cnt, cnt_nxt, cnt_inc, run_n;
  logic                 det_nxt, start_nxt;

  // Whole pipeline freezes together while the output beat is stalled.
  assign en        = ~out_tvalid | out_tready;
  assign in_tready = en;

  assign i_sq = SW'(PW'(in_itdata) * PW'(in_itdata));
  assign q_sq = SW'(PW'(in_qtdata) * PW'(in_qtdata));
  assign sum  = {1'b0, s1_isq} + {1'b0, s1_qsq};

  assign run_n   = (min_run == '0) ? RUN_WIDTH'(1) : min_run;
  assign cnt_inc = (&cnt) ? cnt : cnt + RUN_WIDTH'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (sum >= thresh_on) begin
          cnt_nxt   = RUN_WIDTH'(1);
          state_nxt = (run_n == RUN_WIDTH'(1)) ? ACTIVE : QUALIFY;
        end
      end
      QUALIFY: begin
        if (sum >= thresh_on) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= run_n) state_nxt = ACTIVE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      ACTIVE: begin
        if (sum < thresh_off) begin
          cnt_nxt   = RUN_WIDTH'(1);
          state_nxt = (run_n == RUN_WIDTH'(1)) ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        if (sum < thresh_off) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= run_n) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt   = '0;
          state_nxt = ACTIVE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    det_nxt   = (state_nxt == ACTIVE) || (state_nxt == RELEASE);
    start_nxt = det_nxt && ((state == IDLE) || (state == QUALIFY));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, because out_pwr/out_tlast are
      // architecturally visible with defined reset values.
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_isq     <= '0;
      s1_qsq     <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_pwr    <= '0;
      out_det    <= 1'b0;
      out_start  <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
    end else if (clear) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_isq     <= '0;
      s1_qsq     <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_pwr    <= '0;
      out_det    <= 1'b0;
      out_start  <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
    end else if (en) begin
      s1_valid <= in_tvalid;
      if (in_tvalid) begin
        s1_last <= in_tlast;
        s1_isq  <= i_sq;
        s1_qsq  <= q_sq;
      end
      out_tvalid <= s1_valid;
      // Detector advances exactly once per beat entering the output stage.
      if (s1_valid) begin
        out_tlast <= s1_last;
        out_pwr   <= sum;
        out_det   <= det_nxt;
        out_start <= start_nxt;
        state     <= state_nxt;
        cnt       <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cavg_power_detect.sv
// Self-checking bench for cavg_power_detect: directed cases plus randomized
// traffic and backpressure scored against an arithmetic reference model.
module tb_cavg_power_detect;

  localparam int DW = 16;
  localparam int RW = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clear = 1'b0;
  logic [2*DW-1:0]      thresh_on = '1;
  logic [2*DW-1:0]      thresh_off = '1;
  logic [RW-1:0]        min_run = RW'(1);
  logic                 in_tvalid = 1'b0;
  logic                 in_tlast = 1'b0;
  logic                 in_tready;
  logic signed [DW-1:0] in_itdata = '0;
  logic signed [DW-1:0] in_qtdata = '0;
  logic                 out_tvalid, out_tlast, out_det, out_start;
  logic                 out_tready = 1'b0;
  logic [2*DW-1:0]      out_pwr;

  always #5 clk = ~clk;

  cavg_power_detect #(.DATA_WIDTH(DW), .RUN_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .thresh_on(thresh_on), .thresh_off(thresh_off), .min_run(min_run),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .in_itdata(in_itdata), .in_qtdata(in_qtdata),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
    .out_pwr(out_pwr), .out_det(out_det), .out_start(out_start)
  );

  typedef struct {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    bit                   last;
  } beat_t;

  typedef struct {
    longint pwr;
    bit     det;
    bit     start;
    bit     last;
    int     acc;  // accept cycle (expected) or latency (logged)
  } res_t;

  beat_t       src[$];
  res_t        exp_q[$];
  res_t        log_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_run = 0;
  bit          stall_prev = 1'b0;
  logic [34:0] held = '0;

  bit exp_det3[10]   = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
  bit exp_start3[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  int pwr_sel3[10]   = '{121, 121, 40, 121, 121, 121, 61, 40, 40, 40};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Detector seen as: a flag, and a run of consecutive samples that argue for
  // flipping it; the flag flips once the run reaches max(min_run,1).
  function automatic res_t model(input beat_t b);
    res_t   r;
    longint p;
    int     n;
    bit     qual;
    p    = longint'(b.i) * longint'(b.i) + longint'(b.q) * longint'(b.q);
    n    = (min_run == 0) ? 1 : int'(min_run);
    qual = m_active ? (p < longint'(thresh_off)) : (p >= longint'(thresh_on));
    r.start = 1'b0;
    if (qual) begin
      m_run = (m_run < 255) ? m_run + 1 : 255;
      if (m_run >= n) begin
        m_active = !m_active;
        r.start  = m_active;
        m_run    = 0;
      end
    end else begin
      m_run = 0;
    end
    r.pwr  = p;
    r.det  = m_active;
    r.last = b.last;
    r.acc  = cyc;
    return r;
  endfunction

  task automatic push(input int i, input int q, input bit last);
    beat_t b;
    b.i    = i[DW-1:0];
    b.q    = q[DW-1:0];
    b.last = last;
    src.push_back(b);
  endtask

  // One clock: drive at posedge+1, observe at the following negedge.
  task automatic tick(input bit vld, input bit rdy, input bit clr = 1'b0);
    res_t e, o;
    out_tready = rdy;
    clear      = clr;
    in_tvalid  = vld && (src.size() > 0);
    if (in_tvalid) begin
      in_itdata = src[0].i;
      in_qtdata = src[0].q;
      in_tlast  = src[0].last;
    end
    @(negedge clk);
    if (clr) begin
      exp_q.delete();
      m_active   = 1'b0;
      m_run      = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_tvalid, 1);
        check("stall_data", {out_pwr, out_det, out_start, out_tlast}, held);
      end
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", out_pwr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_pwr", out_pwr, e.pwr);
          check("sb_det", out_det, e.det);
          check("sb_start", out_start, e.start);
          check("sb_last", out_tlast, e.last);
          o.pwr   = out_pwr;
          o.det   = out_det;
          o.start = out_start;
          o.last  = out_tlast;
          o.acc   = cyc - e.acc;
          log_q.push_back(o);
        end
      end
      if (in_tvalid && in_tready) exp_q.push_back(model(src.pop_front()));
      stall_prev = out_tvalid && !out_tready;
      held       = {out_pwr, out_det, out_start, out_tlast};
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int vld_pct, input int rdy_pct, input int budget);
    int k = 0;
    while ((src.size() > 0 || exp_q.size() > 0) && k < budget) begin
      tick($urandom_range(99, 0) < vld_pct, $urandom_range(99, 0) < rdy_pct);
      k++;
    end
    if (src.size() > 0 || exp_q.size() > 0)
      check("drain_timeout", src.size() + exp_q.size(), 0);
    repeat (3) tick(1'b0, 1'b1);
  endtask

  initial begin
    bit hi = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_tvalid", out_tvalid, 0);
    check("rst_tlast", out_tlast, 0);
    check("rst_pwr", out_pwr, 0);
    check("rst_det", out_det, 0);
    check("rst_start", out_start, 0);
    check("rst_tready", in_tready, 1);
    @(posedge clk);
    #1;

    // 3/4 triangle, full throughput
    log_q.delete();
    for (int k = 1; k <= 5; k++) push(3, 4, k == 5);
    drain(100, 100, 50);
    check("t1_count", log_q.size(), 5);
    foreach (log_q[k]) begin
      check("t1_pwr", log_q[k].pwr, 25);
      check("t1_last", log_q[k].last, k == 4);
    end
    check("t1_latency", log_q[0].acc, 2);

    // extreme inputs
    log_q.delete();
    push(-32768, -32768, 0);
    push(32767, 0, 1);
    drain(100, 100, 50);
    check("t2_count", log_q.size(), 2);
    check("t2_pwr_min", log_q[0].pwr, 64'h8000_0000);
    check("t2_pwr_max", log_q[1].pwr, 64'h3FFF_0001);

    // qualified entry and release, min_run=3
    tick(1'b0, 1'b1, 1'b1);
    thresh_on  = 32'd100;
    thresh_off = 32'd50;
    min_run    = RW'(3);
    log_q.delete();
    for (int k = 0; k < 10; k++) begin
      case (pwr_sel3[k])
        121:     push(11, 0, 0);
        61:      push(6, 5, 0);
        default: push(6, 2, 0);
      endcase
    end
    drain(100, 100, 80);
    check("t3_count", log_q.size(), 10);
    foreach (log_q[k]) begin
      check("t3_det", log_q[k].det, exp_det3[k]);
      check("t3_start", log_q[k].start, exp_start3[k]);
    end

    // min_run=0 acts as 1; threshold equality boundaries
    tick(1'b0, 1'b1, 1'b1);
    min_run = '0;
    log_q.delete();
    push(10, 0, 0);  // p=100 == thresh_on
    push(7, 1, 0);   // p=50  == thresh_off, holds
    push(7, 0, 0);   // p=49, releases immediately
    push(10, 0, 0);
    drain(100, 100, 50);
    check("t4_count", log_q.size(), 4);
    check("t4_det0", log_q[0].det, 1);
    check("t4_start0", log_q[0].start, 1);
    check("t4_det1", log_q[1].det, 1);
    check("t4_start1", log_q[1].start, 0);
    check("t4_det2", log_q[2].det, 0);
    check("t4_det3", log_q[3].det, 1);
    check("t4_start3", log_q[3].start, 1);

    // randomized traffic with backpressure
    for (int seg = 0; seg < 2; seg++) begin
      tick(1'b0, 1'b1, 1'b1);
      thresh_on  = 32'h2000_0000 + $urandom_range(32'h0FFF_FFFF, 0);
      thresh_off = thresh_on - $urandom_range(32'h0FFF_FFFF, 0);
      min_run    = RW'($urandom_range(seg * 2 + 3, 0));
      log_q.delete();
      for (int k = 0; k < 500; k++) begin
        if ($urandom_range(99, 0) < 20) hi = !hi;
        if ($urandom_range(99, 0) < 3)
          push(-32768, -32768, $urandom_range(1, 0) == 1);
        else if (hi)
          push(int'($urandom_range(65535, 0)) - 32768, int'($urandom_range(65535, 0)) - 32768,
               $urandom_range(7, 0) == 0);
        else
          push(int'($urandom_range(16383, 0)) - 8192, int'($urandom_range(16383, 0)) - 8192,
               $urandom_range(7, 0) == 0);
      end
      drain(75, 50, 6000);
      check("rand_count", log_q.size(), 500);
    end

    // clear while ACTIVE with two beats in flight
    tick(1'b0, 1'b1, 1'b1);
    thresh_on  = 32'd100;
    thresh_off = 32'd50;
    min_run    = RW'(1);
    push(10, 0, 0);
    drain(100, 100, 20);
    push(11, 0, 0);
    push(11, 0, 1);
    repeat (3) tick(1'b1, 1'b0);
    check("clr_inflight", exp_q.size(), 2);
    check("clr_pre_valid", out_tvalid, 1);
    tick(1'b0, 1'b0, 1'b1);
    check("clr_flush", out_tvalid, 0);
    min_run = RW'(2);
    log_q.delete();
    push(11, 0, 0);
    push(11, 0, 0);
    drain(100, 100, 30);
    check("clr_count", log_q.size(), 2);
    check("clr_det0", log_q[0].det, 0);
    check("clr_det1", log_q[1].det, 1);
    check("clr_start1", log_q[1].start, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
